// File: rtl/axis_fir_decimator.sv
// axis_fir_decimator
// Post-FIR stage: rounds/saturates 32-bit accumulator samples to Q15, keeps one
// of every D samples and re-frames them on an AXI-Stream master with tlast
// every FRAME_LEN outputs. A 4-entry output buffer absorbs backpressure.
//
// Ports
//   s_axis_aclk, s_axis_aresetn : clock, synchronous active-low reset
//   s_axis_t*                   : input stream (tstrb ignored, tlast resyncs phase)
//   m_axis_t*                   : output stream (tstrb constant all-ones)
//   decim_factor                : D (0 -> 1, >MAX_DECIM -> MAX_DECIM)
//   enable                      : 1 = accept input, 0 = stall input, keep draining
//   sat_count                   : clipped-sample counter, present only when
//                                 DECIM_SAT_COUNT_EN is defined
module axis_fir_decimator #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FRAC_SHIFT           = 15,
    parameter int unsigned MAX_DECIM            = 16,
    parameter int unsigned FRAME_LEN            = 1024
) (
    input  logic                                s_axis_aclk,
    input  logic                                s_axis_aresetn,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] s_axis_tstrb,
    input  logic                                s_axis_tlast,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] m_axis_tstrb,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    input  logic [4:0]                          decim_factor,
    input  logic                                enable
`ifdef DECIM_SAT_COUNT_EN
    ,
    output logic [15:0]                         sat_count
`endif
);

    localparam int unsigned SW  = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned MW  = C_M_AXIS_TDATA_WIDTH;
    localparam int unsigned EW  = SW + 1;
    localparam int unsigned PW  = (MAX_DECIM > 1) ? $clog2(MAX_DECIM) : 1;
    localparam int unsigned DW  = $clog2(MAX_DECIM + 1);
    localparam int unsigned FW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned AW  = 2;
    localparam int unsigned CW  = 3;
    localparam int unsigned QW  = 16;

    localparam logic signed [EW-1:0] HALF = EW'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [EW-1:0] QMAX = EW'(32767);
    localparam logic signed [EW-1:0] QMIN = ~QMAX;

    // State
    logic [PW-1:0]   phase;
    logic [DW-1:0]   d_lat;
    logic            pipe_valid;
    logic [MW-1:0]   pipe_data;
    logic [MW-1:0]   mem [2**AW];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [FW-1:0]   frame;

    // Next-state
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shifted;
    logic signed [QW-1:0] sat_val;
    logic                 clip;
    logic [DW-1:0]        d_eff;
    logic                 accept;
    logic                 keep;
    logic                 push;
    logic                 pop;
    logic [PW-1:0]        phase_nxt;
    logic [DW-1:0]        d_lat_nxt;
    logic [MW-1:0]        pipe_data_nxt;
    logic [CW-1:0]        count_nxt;
    logic [CW-1:0]        occ_nxt;
    logic [AW-1:0]        rd_nxt;
    logic [AW-1:0]        wr_nxt;
    logic [FW-1:0]        frame_nxt;
    logic [MW-1:0]        head_nxt;
    logic                 tready_nxt;

    logic unused_strb;
    assign unused_strb  = ^s_axis_tstrb;
    assign m_axis_tstrb = '1;

    // Round-half-up, saturate, decimate and buffer bookkeeping
    always_comb begin
        ext           = EW'($signed(s_axis_tdata));
        rnd           = '0;
        shifted       = '0;
        sat_val       = '0;
        clip          = 1'b0;
        d_eff         = DW'(1);
        accept        = s_axis_tvalid & s_axis_tready;
        keep          = 1'b0;
        push          = pipe_valid;
        pop           = m_axis_tvalid & m_axis_tready;
        phase_nxt     = phase;
        d_lat_nxt     = d_lat;
        pipe_data_nxt = pipe_data;
        count_nxt     = count;
        occ_nxt       = '0;
        rd_nxt        = rd_ptr;
        wr_nxt        = wr_ptr;
        frame_nxt     = frame;
        head_nxt      = mem[rd_ptr];
        tready_nxt    = 1'b0;

        rnd     = ext + HALF;
        shifted = rnd >>> FRAC_SHIFT;
        if (shifted > QMAX) begin
            sat_val = 16'sh7FFF;
            clip    = 1'b1;
        end else if (shifted < QMIN) begin
            sat_val = -16'sh8000;
            clip    = 1'b1;
        end else begin
            sat_val = shifted[QW-1:0];
        end

        if (32'(decim_factor) == 32'd0) begin
            d_eff = DW'(1);
        end else if (32'(decim_factor) > MAX_DECIM) begin
            d_eff = DW'(MAX_DECIM);
        end else begin
            d_eff = DW'(decim_factor);
        end

        // Factor is latched only when a new decimation period begins
        if (accept) begin
            if (phase == '0) begin
                keep          = 1'b1;
                d_lat_nxt     = d_eff;
                pipe_data_nxt = MW'(sat_val);
                phase_nxt     = (d_eff == DW'(1)) ? PW'(0) : PW'(1);
            end else if (32'(phase) + 32'd1 >= 32'(d_lat)) begin
                phase_nxt = '0;
            end else begin
                phase_nxt = phase + PW'(1);
            end
            if (s_axis_tlast) begin
                phase_nxt = '0;
            end
        end

        count_nxt = count + CW'(push) - CW'(pop);
        if (push) begin
            wr_nxt = wr_ptr + AW'(1);
        end
        if (pop) begin
            rd_nxt = rd_ptr + AW'(1);
            frame_nxt = (frame == FW'(FRAME_LEN - 1)) ? FW'(0) : frame + FW'(1);
        end

        // New head is the incoming pipe sample when it lands in the head slot
        if (push && (rd_nxt == wr_ptr)) begin
            head_nxt = pipe_data;
        end else begin
            head_nxt = mem[rd_nxt];
        end

        occ_nxt    = count_nxt + CW'(keep);
        tready_nxt = enable & (occ_nxt < CW'(3));
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            phase         <= '0;
            d_lat         <= DW'(1);
            pipe_valid    <= 1'b0;
            pipe_data     <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            frame         <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            phase         <= phase_nxt;
            d_lat         <= d_lat_nxt;
            pipe_valid    <= keep;
            pipe_data     <= pipe_data_nxt;
            rd_ptr        <= rd_nxt;
            wr_ptr        <= wr_nxt;
            count         <= count_nxt;
            frame         <= frame_nxt;
            s_axis_tready <= tready_nxt;
            m_axis_tvalid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                m_axis_tdata <= head_nxt;
            end
            m_axis_tlast  <= (count_nxt != '0) && (frame_nxt == FW'(FRAME_LEN - 1));
        end
    end

    // Buffer storage needs no reset; occupancy tracking guards every read
    always_ff @(posedge s_axis_aclk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

`ifdef DECIM_SAT_COUNT_EN
    // Clipped kept samples, sticky at all-ones
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            sat_count <= '0;
        end else if (keep && clip && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_fir_decimator.sv
// Scoreboard bench for axis_fir_decimator (FRAME_LEN overridden to 8).
module tb_axis_fir_decimator;

    localparam int unsigned FL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  decim;
    logic        enable;
`ifdef DECIM_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int out_cnt = 0;
    int tlast_seen = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    axis_fir_decimator #(.FRAME_LEN(FL)) dut (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .decim_factor  (decim),
        .enable        (enable)
`ifdef DECIM_SAT_COUNT_EN
        ,
        .sat_count     (sat_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the DUT takes it
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        bit ok = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
            n++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h never accepted", d);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: pop expected value on every output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            out_cnt = 0;
        end else if (m_tvalid && m_tready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", m_tdata, 32'hDEADBEEF);
            end else begin
                chk("out_data", m_tdata, exp_q.pop_front());
            end
            chk("out_tlast", 32'(m_tlast), 32'((out_cnt % FL) == FL - 1));
            chk("out_tstrb", 32'(m_tstrb), 32'hF);
            if (m_tlast) tlast_seen++;
            out_cnt++;
        end
    end

    initial begin
        int base;
        int cyc;
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        decim    = 5'd1;
        enable   = 1'b1;
        tick();
        tick();
        do_reset();
        tick();
        chk("ready_after_reset", 32'(s_tready), 32'd1);

        // Rounding around half LSB
        exp_q.push_back(32'h00000001);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00000000);
        send(32'h00004000, 1'b0);
        send(32'h00003FFF, 1'b0);
        send(32'hFFFFC000, 1'b0);
        drain();

        // Saturation both rails
        exp_q.push_back(32'h00007FFF);
        exp_q.push_back(32'hFFFF8000);
        send(32'h7FFFFFFF, 1'b0);
        send(32'h80000000, 1'b0);
        drain();
`ifdef DECIM_SAT_COUNT_EN
        chk("sat_count", 32'(sat_count), 32'd2);
`endif

        // D=4 keeps 0,4,8,12
        decim = 5'd4;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd4);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd12);
        for (int k = 0; k < 16; k++) send(32'(k) << 15, 1'b0);
        drain();

        // D=0 acts as D=1
        decim = 5'd0;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        send(32'h00008000, 1'b0);
        send(32'h00010000, 1'b0);
        send(32'h00018000, 1'b0);
        drain();

        // enable low blocks input
        decim  = 5'd1;
        enable = 1'b0;
        tick();
        tick();
        chk("enable_low_tready", 32'(s_tready), 32'd0);
        enable = 1'b1;
        tick();
        tick();
        chk("enable_high_tready", 32'(s_tready), 32'd1);

        // Backpressure: fill, stall, release, 10 in order back to back
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) exp_q.push_back(32'(100 + k));
        base = hs_count;
        fork
            begin
                for (int k = 0; k < 10; k++) send(32'(100 + k) << 15, 1'b0);
            end
            begin
                repeat (12) tick();
                chk("bp_tready_low", 32'(s_tready), 32'd0);
                chk("bp_tvalid_high", 32'(m_tvalid), 32'd1);
                chk("bp_no_output", 32'(hs_count - base), 32'd0);
                m_tready = 1'b1;
                cyc = 0;
                while (hs_count < base + 10 && cyc < 100) begin
                    @(negedge clk);
                    #1;
                    cyc++;
                end
                chk("bp_drain_cycles", 32'(cyc), 32'd10);
            end
        join
        drain();

        // Framing: 16 outputs after reset, tlast on 7 and 15
        do_reset();
        tlast_seen = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(32'(k));
        for (int k = 0; k < 16; k++) send(32'(k) << 15, 1'b0);
        drain();
        chk("tlast_count", 32'(tlast_seen), 32'd2);

        // D=3, tlast on input 4 resyncs: keep 0,3,5,8
        decim = 5'd3;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd8);
        for (int k = 0; k < 9; k++) send(32'(k) << 15, (k == 4));
        drain();

        // Reset with data stuck in the buffer discards it
        m_tready = 1'b0;
        decim    = 5'd1;
        for (int k = 0; k < 4; k++) send(32'(50 + k) << 15, 1'b0);
        repeat (3) tick();
        chk("pre_reset_tvalid", 32'(m_tvalid), 32'd1);
        do_reset();
        m_tready = 1'b1;
        exp_q.push_back(32'd7);
        send(32'd7 << 15, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
